aes_key_sched_ctrl: RTL and testbench

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_key_sched_ctrl_if.sv | 34 +++
 rtl/aes_key_sched_ctrl.sv | 168 ++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_ctrl_if.sv
// Bundles the key-schedule controller's host, round-key stream and expansion-unit signals.
// master: the controller side; slave: the host, consumer and expansion unit side.
interface aes_key_sched_ctrl_if;
    logic [255:0] key_in;
    logic         key_load;
    logic         start;
    logic         decrypt;
    logic         key_busy;
    logic         key_valid;
    logic         key_err;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         ke_Rst;
    logic         ke_En;
    logic [255:0] ke_data_in;
    logic [3:0]   ke_Addr_Key;
    logic         ke_ready;
    logic [127:0] ke_Out_Key;

    modport master (
        input  key_in, key_load, start, decrypt, rk_ready, ke_ready, ke_Out_Key,
        output key_busy, key_valid, key_err, rk_out, rk_idx, rk_valid, rk_last,
               ke_Rst, ke_En, ke_data_in, ke_Addr_Key
    );

    modport slave (
        output key_in, key_load, start, decrypt, rk_ready, ke_ready, ke_Out_Key,
        input  key_busy, key_valid, key_err, rk_out, rk_idx, rk_valid, rk_last,
               ke_Rst, ke_En, ke_data_in, ke_Addr_Key
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule controller: drives an external expansion unit, then streams its
// round keys ascending or descending over a valid/ready handshake, one key per two cycles.
module aes_key_sched_ctrl #(
    parameter int unsigned NKEYS       = 15,
    parameter int unsigned EXP_TIMEOUT = 255
) (
    input  logic                        Clk,
    input  logic                        Rst,
    aes_key_sched_ctrl_if.master        bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] KCLR    = 3'd1;
    localparam logic [2:0] EXPAND  = 3'd2;
    localparam logic [2:0] READY   = 3'd3;
    localparam logic [2:0] FETCH   = 3'd4;
    localparam logic [2:0] PRESENT = 3'd5;

    localparam int unsigned CntW        = (EXP_TIMEOUT > 1) ? $clog2(EXP_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(EXP_TIMEOUT - 1);
    localparam logic [3:0] LastIdx      = 4'(NKEYS - 1);

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] exp_cnt_q, exp_cnt_d;
    logic [3:0]      idx_q, idx_d;
    logic            dir_q, dir_d;
    logic            key_valid_q, key_valid_d;
    logic            key_err_q, key_err_d;
    logic            key_busy_q, key_busy_d;
    logic [127:0]    rk_out_q, rk_out_d;
    logic [3:0]      rk_idx_q, rk_idx_d;
    logic            rk_valid_q, rk_valid_d;
    logic            rk_last_q, rk_last_d;
    logic            ke_rst_q, ke_rst_d;
    logic            ke_en_q, ke_en_d;
    logic [255:0]    ke_data_q, ke_data_d;
    logic [3:0]      ke_addr_q, ke_addr_d;

    logic accept_load;
    logic xfer;

    always_comb begin
        state_d     = state_q;
        exp_cnt_d   = exp_cnt_q;
        idx_d       = idx_q;
        dir_d       = dir_q;
        key_valid_d = key_valid_q;
        key_err_d   = key_err_q;
        rk_out_d    = rk_out_q;
        rk_idx_d    = rk_idx_q;
        rk_valid_d  = rk_valid_q;
        rk_last_d   = rk_last_q;
        ke_data_d   = ke_data_q;

        accept_load = bus.key_load && (state_q == IDLE || state_q == READY);
        xfer        = rk_valid_q && bus.rk_ready;

        case (state_q)
            IDLE: ;
            KCLR: begin
                exp_cnt_d = '0;
                state_d   = EXPAND;
            end
            EXPAND: begin
                if (bus.ke_ready) begin
                    key_valid_d = 1'b1;
                    state_d     = READY;
                end else if (exp_cnt_q == CntLast) begin
                    key_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    exp_cnt_d = exp_cnt_q + 1'b1;
                end
            end
            READY: begin
                // key_load wins a same-cycle collision; that start is dropped
                if (bus.start && !bus.key_load) begin
                    dir_d   = bus.decrypt;
                    idx_d   = bus.decrypt ? LastIdx : 4'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rk_out_d   = bus.ke_Out_Key;
                rk_idx_d   = idx_q;
                rk_valid_d = 1'b1;
                rk_last_d  = dir_q ? (idx_q == 4'd0) : (idx_q == LastIdx);
                state_d    = PRESENT;
            end
            PRESENT: begin
                if (xfer) begin
                    rk_valid_d = 1'b0;
                    rk_last_d  = 1'b0;
                    if (rk_last_q) begin
                        state_d = READY;
                    end else begin
                        idx_d   = dir_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_load) begin
            ke_data_d   = bus.key_in;
            key_valid_d = 1'b0;
            key_err_d   = 1'b0;
            state_d     = KCLR;
        end

        // Moore outputs are registered from the next state so they line up with state_q
        ke_addr_d  = (state_d == FETCH) ? idx_d : ke_addr_q;
        ke_rst_d   = (state_d != KCLR);
        ke_en_d    = (state_d == EXPAND);
        key_busy_d = (state_d == KCLR) || (state_d == EXPAND) ||
                     (state_d == FETCH) || (state_d == PRESENT);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            exp_cnt_q   <= '0;
            idx_q       <= '0;
            dir_q       <= 1'b0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
            key_busy_q  <= 1'b0;
            rk_out_q    <= '0;
            rk_idx_q    <= '0;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
            ke_rst_q    <= 1'b0;
            ke_en_q     <= 1'b0;
            ke_data_q   <= '0;
            ke_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            exp_cnt_q   <= exp_cnt_d;
            idx_q       <= idx_d;
            dir_q       <= dir_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
            key_busy_q  <= key_busy_d;
            rk_out_q    <= rk_out_d;
            rk_idx_q    <= rk_idx_d;
            rk_valid_q  <= rk_valid_d;
            rk_last_q   <= rk_last_d;
            ke_rst_q    <= ke_rst_d;
            ke_en_q     <= ke_en_d;
            ke_data_q   <= ke_data_d;
            ke_addr_q   <= ke_addr_d;
        end
    end

    assign bus.key_busy    = key_busy_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_err     = key_err_q;
    assign bus.rk_out      = rk_out_q;
    assign bus.rk_idx      = rk_idx_q;
    assign bus.rk_valid    = rk_valid_q;
    assign bus.rk_last     = rk_last_q;
    assign bus.ke_Rst      = ke_rst_q;
    assign bus.ke_En       = ke_en_q;
    assign bus.ke_data_in  = ke_data_q;
    assign bus.ke_Addr_Key = ke_addr_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: stub expansion unit, scoreboard of expected round keys,
// table of streaming passes plus hand-written expansion, collision, timeout and reset cases.
module tb_aes_key_sched_ctrl;

    logic Clk;
    logic Rst;
    aes_key_sched_ctrl_if bus ();

    aes_key_sched_ctrl #(
        .NKEYS       (15),
        .EXP_TIMEOUT (255)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stub expansion unit: ready 10 enabled cycles after its reset, key = {32{addr}}
    logic       stub_never;
    logic [3:0] st_cnt;
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)                                st_cnt <= '0;
        else if (!bus.ke_Rst)                    st_cnt <= '0;
        else if (bus.ke_En && st_cnt != 4'd10)   st_cnt <= st_cnt + 4'd1;
    end
    assign bus.ke_ready   = !stub_never && (st_cnt == 4'd10);
    assign bus.ke_Out_Key = {32{bus.ke_Addr_Key}};

    bit rand_mode;
    always @(posedge Clk) begin
        #1;
        if (rand_mode) bus.rk_ready = 1'($urandom_range(0, 1));
        else           bus.rk_ready = 1'b1;
    end

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         last;
    } exp_t;
    exp_t exp_q[$];

    int           xfers;
    int           valid_seen;
    logic [3:0]   first_idx_seen;
    logic [3:0]   last_idx_seen;
    bit           prev_stall;
    logic [127:0] sv_out;
    logic [3:0]   sv_idx;
    logic         sv_last;

    // Consumer-side monitor: stall stability and scoreboard on each transfer
    always @(negedge Clk) begin
        if (!Rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.rk_valid) valid_seen++;
            if (prev_stall) begin
                check("stall_valid", bus.rk_valid, 1'b1);
                check("stall_out", bus.rk_out, sv_out);
                check("stall_idx", bus.rk_idx, sv_idx);
                check("stall_last", bus.rk_last, sv_last);
            end
            if (bus.rk_valid && bus.rk_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer_idx", bus.rk_idx, 4'hx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rk_idx", bus.rk_idx, e.idx);
                    check("rk_out", bus.rk_out, e.key);
                    check("rk_last", bus.rk_last, e.last);
                end
                if (xfers == 0) first_idx_seen = bus.rk_idx;
                if (bus.rk_last) last_idx_seen = bus.rk_idx;
                xfers++;
            end
            prev_stall = bus.rk_valid && !bus.rk_ready;
            sv_out     = bus.rk_out;
            sv_idx     = bus.rk_idx;
            sv_last    = bus.rk_last;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, bus.key_busy, 1'b0);
        check({tag, "_kvalid"}, bus.key_valid, 1'b0);
        check({tag, "_kerr"}, bus.key_err, 1'b0);
        check({tag, "_rkvalid"}, bus.rk_valid, 1'b0);
        check({tag, "_rklast"}, bus.rk_last, 1'b0);
        check({tag, "_rkout"}, bus.rk_out, 128'd0);
        check({tag, "_rkidx"}, bus.rk_idx, 4'd0);
        check({tag, "_kerst"}, bus.ke_Rst, 1'b0);
        check({tag, "_keen"}, bus.ke_En, 1'b0);
        check({tag, "_kedata"}, bus.ke_data_in, 256'd0);
        check({tag, "_keaddr"}, bus.ke_Addr_Key, 4'd0);
    endtask

    task automatic load_key(input logic [255:0] k, input bit with_start, input int exp_en,
                            input bit exp_ok);
        int n;
        int rst_lo;
        int en_hi;
        @(posedge Clk); #1;
        bus.key_in   = k;
        bus.key_load = 1'b1;
        bus.start    = with_start;
        bus.decrypt  = 1'b0;
        @(posedge Clk); #1;
        bus.key_load = 1'b0;
        bus.start    = 1'b0;
        n = 0; rst_lo = 0; en_hi = 0;
        while (bus.key_busy && n < 600) begin
            if (!bus.ke_Rst) rst_lo++;
            if (bus.ke_En) en_hi++;
            @(posedge Clk); #1;
            n++;
        end
        check("load_done", bus.key_busy, 1'b0);
        check("kclr_cycles", rst_lo, 1);
        check("expand_cycles", en_hi, exp_en);
        check("load_kvalid", bus.key_valid, exp_ok);
        check("load_kerr", bus.key_err, !exp_ok);
        check("load_keen", bus.ke_En, 1'b0);
        check("load_kedata", bus.ke_data_in, k);
    endtask

    task automatic push_pass(input bit dec);
        for (int i = 0; i < 15; i++) begin
            exp_t e;
            e.idx  = dec ? 4'(14 - i) : 4'(i);
            e.key  = {32{e.idx}};
            e.last = (i == 14);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_pass(input bit dec, input bit rnd, input bit inject, output int cycles);
        int n;
        rand_mode = rnd;
        push_pass(dec);
        xfers = 0;
        @(posedge Clk); #1;
        bus.start   = 1'b1;
        bus.decrypt = dec;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.key_busy && n < 400) begin
            if (inject && n == 5) begin
                bus.key_in   = {8{32'hdeadbeef}};
                bus.key_load = 1'b1;
            end
            if (n == 6) bus.key_load = 1'b0;
            @(posedge Clk); #1;
            n++;
        end
        bus.key_load = 1'b0;
        cycles = n;
        rand_mode = 1'b0;
    endtask

    typedef struct {
        bit         dec;
        bit         rnd;
        bit         inject;
        int         exp_cycles;
        logic [3:0] first_idx;
        logic [3:0] last_idx;
    } pass_t;

    logic [255:0] key0;
    logic [255:0] key1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pass_t tbl[5];
        int cyc;
        int busy_seen;
        int n;
        tbl[0] = '{dec: 1'b0, rnd: 1'b0, inject: 1'b0, exp_cycles: 30, first_idx: 4'd0,  last_idx: 4'd14};
        tbl[1] = '{dec: 1'b1, rnd: 1'b1, inject: 1'b0, exp_cycles: 0,  first_idx: 4'd14, last_idx: 4'd0};
        tbl[2] = '{dec: 1'b0, rnd: 1'b1, inject: 1'b0, exp_cycles: 0,  first_idx: 4'd0,  last_idx: 4'd14};
        tbl[3] = '{dec: 1'b1, rnd: 1'b0, inject: 1'b0, exp_cycles: 30, first_idx: 4'd14, last_idx: 4'd0};
        tbl[4] = '{dec: 1'b0, rnd: 1'b0, inject: 1'b1, exp_cycles: 30, first_idx: 4'd0,  last_idx: 4'd14};

        for (int i = 0; i < 32; i++) key0[255 - 8*i -: 8] = 8'(i);
        key1 = {8{32'h0badf00d}};

        stub_never   = 1'b0;
        rand_mode    = 1'b0;
        xfers        = 0;
        valid_seen   = 0;
        bus.key_in   = '0;
        bus.key_load = 1'b0;
        bus.start    = 1'b0;
        bus.decrypt  = 1'b0;
        bus.rk_ready = 1'b1;
        Rst = 1'b1;
        #2 Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1 check_reset_vals("reset");
        @(negedge Clk) Rst = 1'b1;
        @(posedge Clk); #1;
        check("kerst_after_release", bus.ke_Rst, 1'b1);

        load_key(key0, 1'b0, 11, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run_pass(tbl[i].dec, tbl[i].rnd, tbl[i].inject, cyc);
            check("pass_xfers", xfers, 15);
            check("pass_queue_empty", exp_q.size(), 0);
            check("pass_first_idx", first_idx_seen, tbl[i].first_idx);
            check("pass_last_idx", last_idx_seen, tbl[i].last_idx);
            check("pass_kvalid", bus.key_valid, 1'b1);
            check("pass_rkvalid_low", bus.rk_valid, 1'b0);
            check("pass_kedata", bus.ke_data_in, key0);
            if (tbl[i].exp_cycles != 0) check("pass_cycles", cyc, tbl[i].exp_cycles);
        end

        // key_load and start together in READY: re-expand, no streaming
        xfers = 0;
        load_key(key1, 1'b1, 11, 1'b1);
        repeat (5) @(posedge Clk);
        #1 check("collision_no_xfer", xfers, 0);

        // Expansion never completes: timeout, then start must be ignored
        stub_never = 1'b1;
        load_key(key0, 1'b0, 255, 1'b0);
        xfers = 0; valid_seen = 0; busy_seen = 0;
        @(posedge Clk); #1;
        bus.start = 1'b1;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.key_busy) busy_seen++;
            @(posedge Clk); #1;
        end
        check("timeout_start_busy", busy_seen, 0);
        check("timeout_start_valid", valid_seen, 0);
        check("timeout_kerr_held", bus.key_err, 1'b1);
        stub_never = 1'b0;
        load_key(key0, 1'b0, 11, 1'b1);

        // Reset in the middle of an ascending pass at index 7
        push_pass(1'b0);
        @(posedge Clk); #1;
        bus.start = 1'b1; bus.decrypt = 1'b0;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!(bus.rk_valid && bus.rk_idx == 4'd7) && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
        check("midstream_reached_idx7", bus.rk_idx, 4'd7);
        Rst = 1'b0;
        #1 check_reset_vals("midreset");
        exp_q.delete();
        repeat (2) @(posedge Clk);
        @(negedge Clk) Rst = 1'b1;
        valid_seen = 0;
        @(posedge Clk); #1;
        bus.start = 1'b1;
        @(posedge Clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge Clk);
        #1;
        check("post_reset_no_valid", valid_seen, 0);
        check("post_reset_kvalid", bus.key_valid, 1'b0);
        check("post_reset_busy", bus.key_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
